// File: rtl/mmu_loader.sv
// mmu_loader: collects a 2x2 weight matrix and a 2x2 input matrix from a
// byte-wide host stream, then runs the feeder/array enable for RUN_LEN
// cycles and pulses done. Weights can be reused across matmuls by starting
// a load with inputs_only=1.
module mmu_loader #(
  parameter int RUN_LEN = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  input  logic       inputs_only,
  output logic       host_ready,
  output logic [7:0] weight_0,
  output logic [7:0] weight_1,
  output logic [7:0] weight_2,
  output logic [7:0] weight_3,
  output logic [7:0] input_0,
  output logic [7:0] input_1,
  output logic [7:0] input_2,
  output logic [7:0] input_3,
  output logic       en,
  output logic [2:0] mmu_cycles,
  output logic       done
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CYCLE = 3'(RUN_LEN - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        mode_q, mode_d;      // 1 = inputs-only load
  logic        en_d, done_d;
  logic [2:0]  cyc_d;
  logic        accept;
  logic        eff_mode;            // mode in force for the byte being accepted
  logic [2:0]  wr_sel;              // 0..3 weights, 4..7 inputs
  logic [7:0]  wt_q [4];
  logic [7:0]  in_q [4];

  assign host_ready = (state_q == LOAD);
  assign accept     = host_valid && host_ready;
  // The mode is taken live from inputs_only on byte 0 and from the latch after.
  assign eff_mode   = (idx_q == 3'd0) ? inputs_only : mode_q;
  assign wr_sel     = {eff_mode | idx_q[2], idx_q[1:0]};

  // Next-state and next-output logic for the load/run/done sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    en_d    = 1'b0;
    cyc_d   = 3'd0;
    done_d  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          mode_d = eff_mode;
          if ((eff_mode && idx_q == 3'd3) || (!eff_mode && idx_q == 3'd7)) begin
            state_d = RUN;
            idx_d   = 3'd0;
            en_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      RUN: begin
        if (mmu_cycles == LAST_CYCLE) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          en_d  = 1'b1;
          cyc_d = mmu_cycles + 3'd1;
        end
      end
      DONE: begin
        state_d = LOAD;
        idx_d   = 3'd0;
      end
      default: state_d = LOAD;
    endcase
  end

  // State register plus the registered en/mmu_cycles/done outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    if (!rst_n) begin
      state_q    <= LOAD;
      idx_q      <= 3'd0;
      mode_q     <= 1'b0;
      en         <= 1'b0;
      mmu_cycles <= 3'd0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      en         <= en_d;
      mmu_cycles <= cyc_d;
      done       <= done_d;
    end
  end

  // Matrix buffers: written only on an accepted byte, cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: these small buffers are flops, not RAM, and must read as zero
    // after reset, so they are cleared explicitly element by element.
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wt_q[i] <= 8'd0;
        in_q[i] <= 8'd0;
      end
    end else if (accept) begin
      if (wr_sel[2]) in_q[wr_sel[1:0]] <= host_data;
      else           wt_q[wr_sel[1:0]] <= host_data;
    end
  end

  assign weight_0 = wt_q[0];
  assign weight_1 = wt_q[1];
  assign weight_2 = wt_q[2];
  assign weight_3 = wt_q[3];
  assign input_0  = in_q[0];
  assign input_1  = in_q[1];
  assign input_2  = in_q[2];
  assign input_3  = in_q[3];

endmodule

// File: tb/tb_mmu_loader.sv
// Directed testbench for mmu_loader: default RUN_LEN=6 instance plus a
// RUN_LEN=4 instance driven by the same host stream.
module tb_mmu_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid;
  logic [7:0] host_data;
  logic       inputs_only;

  logic       host_ready, en, done;
  logic [2:0] mmu_cycles;
  logic [7:0] weight_0, weight_1, weight_2, weight_3;
  logic [7:0] input_0, input_1, input_2, input_3;

  logic       host_ready4, en4, done4;
  logic [2:0] mmu_cycles4;
  logic [7:0] weight4_0, weight4_1, weight4_2, weight4_3;
  logic [7:0] input4_0, input4_1, input4_2, input4_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_loader dut (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_data(host_data),
    .inputs_only(inputs_only), .host_ready(host_ready),
    .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
    .input_0(input_0), .input_1(input_1), .input_2(input_2), .input_3(input_3),
    .en(en), .mmu_cycles(mmu_cycles), .done(done)
  );

  mmu_loader #(.RUN_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_data(host_data),
    .inputs_only(inputs_only), .host_ready(host_ready4),
    .weight_0(weight4_0), .weight_1(weight4_1), .weight_2(weight4_2), .weight_3(weight4_3),
    .input_0(input4_0), .input_1(input4_1), .input_2(input4_2), .input_3(input4_3),
    .en(en4), .mmu_cycles(mmu_cycles4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bufs(input string tag, input logic [31:0] w, input logic [31:0] i);
    check({tag, " weights"}, {weight_0, weight_1, weight_2, weight_3}, w);
    check({tag, " inputs"},  {input_0, input_1, input_2, input_3}, i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; host_valid = 1'b0; host_data = 8'h00; inputs_only = 1'b0;
    #2;
    step(); step();
    check("reset en", en, 0);
    check("reset cycles", mmu_cycles, 0);
    check("reset done", done, 0);
    check_bufs("reset", 32'h0, 32'h0);
    rst_n = 1'b1;
    step();
    check("ready after reset", host_ready, 1);

    // Back-to-back full load of bytes 1..8.
    for (int k = 0; k < 8; k++) begin
      host_valid = 1'b1; host_data = 8'(k + 1);
      step();
      if (k < 7) check("full load en low", en, 0);
    end
    host_valid = 1'b0;
    check("run start en", en, 1);
    check("run start cycles", mmu_cycles, 0);
    check("run start ready", host_ready, 0);
    check_bufs("full load", 32'h01020304, 32'h05060708);
    for (int c = 1; c < 6; c++) begin
      step();
      check("run en", en, 1);
      check("run cycles", mmu_cycles, c);
    end
    step();
    check("done pulse", done, 1);
    check("done en", en, 0);
    check("done cycles", mmu_cycles, 0);
    check("done ready", host_ready, 0);
    step();
    check("done drops", done, 0);
    check("ready after done", host_ready, 1);

    // Inputs-only load of 9..12; mode changes after byte 0 are ignored.
    for (int k = 0; k < 4; k++) begin
      host_valid = 1'b1; host_data = 8'(k + 9); inputs_only = (k == 0);
      step();
      if (k < 3) check("inputs-only en low", en, 0);
    end
    check("inputs-only run start", en, 1);
    check_bufs("inputs-only", 32'h01020304, 32'h090a0b0c);
    // Host keeps pushing 0xFF through RUN and DONE.
    host_data = 8'hff;
    for (int c = 1; c < 6; c++) begin
      step();
      check("busy ready low", host_ready, 0);
      check("busy cycles", mmu_cycles, c);
    end
    step();
    check("busy done", done, 1);
    check("busy done ready", host_ready, 0);
    check_bufs("ignored bytes", 32'h01020304, 32'h090a0b0c);
    step();
    host_valid = 1'b0;
    check("back to load", host_ready, 1);
    check_bufs("ignored bytes after done", 32'h01020304, 32'h090a0b0c);

    // Full load with a 3-cycle gap after the second byte.
    for (int k = 0; k < 2; k++) begin
      host_valid = 1'b1; host_data = 8'(k + 1);
      step();
    end
    host_valid = 1'b0; host_data = 8'hee;
    for (int g = 0; g < 3; g++) begin
      step();
      check("gap ready", host_ready, 1);
    end
    for (int k = 2; k < 8; k++) begin
      host_valid = 1'b1; host_data = 8'(k + 1);
      step();
      if (k == 6) check("gap load en low before last", en, 0);
    end
    host_valid = 1'b0;
    check("gap run start", en, 1);
    check_bufs("gap load", 32'h01020304, 32'h05060708);

    // Reset at mmu_cycles==3 with a byte offered on the same edge.
    step(); step(); step();
    check("pre-reset cycles", mmu_cycles, 3);
    rst_n = 1'b0; host_valid = 1'b1; host_data = 8'h55;
    step();
    rst_n = 1'b1; host_valid = 1'b0;
    check("mid-run reset en", en, 0);
    check("mid-run reset cycles", mmu_cycles, 0);
    check("mid-run reset done", done, 0);
    check("mid-run reset ready", host_ready, 1);
    check_bufs("mid-run reset", 32'h0, 32'h0);

    // Fresh full load; compare RUN_LEN=6 and RUN_LEN=4 instances.
    for (int k = 0; k < 8; k++) begin
      host_valid = 1'b1; host_data = 8'(k + 8'h10);
      step();
    end
    host_valid = 1'b0;
    check("index restarted after reset", weight_0, 8'h10);
    check("len4 input_3", input4_3, 8'h17);
    check("len4 start en", en4, 1);
    check("len4 start cycles", mmu_cycles4, 0);
    for (int c = 1; c < 4; c++) begin
      step();
      check("len4 en", en4, 1);
      check("len4 cycles", mmu_cycles4, c);
    end
    step();
    check("len4 done", done4, 1);
    check("len4 en low", en4, 0);
    check("len6 still running", mmu_cycles, 4);
    step();
    check("len4 done drops", done4, 0);
    check("len4 ready", host_ready4, 1);
    check("len6 last cycle", mmu_cycles, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_loader.md
MMU_LOADER -- requirements
Module: mmu_loader

Interface
REQ-001 Parameter: RUN_LEN, default 6, number of compute/drain cycles per matmul (mmu_cycles counts 0..RUN_LEN-1).
REQ-002 clk  input  1  single clock for all state; rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 host_valid  input  1  host byte present on host_data this cycle.
REQ-005 host_data  input  8  host byte, unsigned.
REQ-006 inputs_only  input  1  sampled with the first byte of a load; 1 means reuse stored weights and load 4 input bytes only.
REQ-007 host_ready  output  1  loader accepts a byte this cycle.
REQ-008 weight_0..weight_3  output  8 each  stored 2x2 weight matrix, row-major.
REQ-009 input_0..input_3  output  8 each  stored 2x2 input matrix, row-major.
REQ-010 en  output  1  feeder/array enable; registered.
REQ-011 mmu_cycles  output  3  run-phase cycle index; registered.
REQ-012 done  output  1  single-cycle pulse after the last run cycle; registered.

Function
REQ-013 The FSM SHALL have exactly 3 states: LOAD, RUN, DONE.
REQ-014 host_ready SHALL equal (state==LOAD); it is combinational from the state register only, with no path from host_valid.
REQ-015 A byte SHALL be accepted on a rising edge where host_valid && host_ready.
REQ-016 Full load: byte k (k=0..3) -> weight_k; byte 4+k -> input_k; 8 accepted bytes total.
REQ-017 inputs_only is sampled only on acceptance of byte 0; when 1, the load is 4 bytes (input_0..input_3) and the weights SHALL hold their values.
REQ-018 The load index SHALL be a 3-bit counter; it advances only on acceptance and holds when host_valid=0 (gaps of any length allowed).
REQ-019 On the edge that accepts the final byte of a load, the state SHALL go to RUN, with en=1 and mmu_cycles=0 from that edge.
REQ-020 In RUN, mmu_cycles SHALL increment by 1 every cycle; on the edge where mmu_cycles==RUN_LEN-1, the state SHALL go to DONE with en=0, mmu_cycles=0, and done=1.
REQ-021 DONE SHALL last exactly 1 cycle, then go to LOAD with done=0 and the load index at 0.
REQ-022 Latency: the last accepted byte is followed by exactly RUN_LEN cycles of en=1, then 1 cycle of done=1, then host_ready=1.
REQ-023 host_valid in RUN or DONE SHALL be ignored, with no buffer write and no index change.
REQ-024 weight_* and input_* SHALL stay stable throughout RUN and DONE; they change only on acceptance in LOAD.
REQ-025 en and mmu_cycles SHALL be 0 in LOAD and DONE; mmu_cycles never exceeds RUN_LEN-1 and never wraps.
REQ-026 The mode latched from inputs_only SHALL hold for the whole load; inputs_only changes after byte 0 have no effect.

Reset
REQ-027 With rst_n=0 at a rising edge: state=LOAD, load index=0, all weight_* and input_* = 0, en=0, mmu_cycles=0, done=0, latched mode=full.
REQ-028 Reset SHALL take priority over every other event, including an acceptance on the same edge; a reset mid-RUN drops en on that edge and clears the buffers.
REQ-029 host_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Verification
REQ-030 Back-to-back full load of bytes 1..8 -> weights {1,2,3,4}, inputs {5,6,7,8}; en=1 for 6 cycles with mmu_cycles 0,1,2,3,4,5; done=1 for 1 cycle; host_ready=1 on the next cycle.
REQ-031 Full load with a 3-cycle host_valid gap after byte 2 -> same buffer contents as REQ-030; run start delayed by exactly 3 cycles.
REQ-032 After REQ-030, inputs_only=1 load of bytes 9,10,11,12 -> weights stay {1,2,3,4}, inputs become {9,10,11,12}, and RUN starts on the 4th acceptance.
REQ-033 host_valid held at 1 with data 0xFF throughout RUN and DONE -> buffers unchanged and host_ready=0 throughout.
REQ-034 rst_n=0 asserted at mmu_cycles==3, with host_valid=1 on the same edge -> next cycle en=0, mmu_cycles=0, done=0, all buffers 0, host_ready=1, no byte captured.
REQ-035 With RUN_LEN=4 -> mmu_cycles sequence 0..3, then done; en high for exactly 4 cycles.
